wb_regfile: RTL
===============

Name: wb_regfile

Overview:
Writeback-side consumer of the writeback control encoding (wb_sel, regWEn). It selects the writeback source, commits the result into a 32x32 integer register file, and serves two decode-stage read ports with same-cycle write bypass. It also keeps a retired-instruction counter and flags illegal writeback selects. It sits at the end of the rv32 pipeline, fed by the WB pipeline register and read by the decode stage.

Parameters:
XLEN, 32, data width of registers and writeback sources
NREG, 32, number of architectural registers; index width is log2(NREG)=5
CNT_W, 64, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
wb_valid  input  1  WB stage holds a valid instruction this cycle
wb_sel  input  2  writeback source select: 00 load data, 01 ALU result, 10 PC+4, 11 illegal
reg_wen  input  1  register write enable from writeback control
wb_rd  input  5  destination register index
alu_res  input  XLEN  ALU result
mem_rdata  input  XLEN  load data, already aligned and extended upstream
pc_plus4  input  XLEN  link value for JAL/JALR
rs1_addr  input  5  read port 1 index
rs2_addr  input  5  read port 2 index
rs1_data  output  XLEN  read port 1 data, combinational, bypassed
rs2_data  output  XLEN  read port 2 data, combinational, bypassed
wb_data  output  XLEN  selected writeback value, combinational, for forwarding
wb_we  output  1  effective write strobe this cycle, combinational
wb_err  output  1  registered one-cycle pulse: illegal wb_sel seen with write requested
retire_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset (async, any time, including mid-operation): all NREG registers cleared to 0; retire_cnt = 0; wb_err = 0. A write pending in the reset cycle is discarded. Reads during reset return 0.
- wb_data mux: 00 -> mem_rdata; 01 -> alu_res; 10 -> pc_plus4; 11 -> 0.
- wb_we = wb_valid & reg_wen & (wb_rd != 0) & (wb_sel != 11).
- Commit: on the rising edge with wb_we=1, regs[wb_rd] <= wb_data. Latency is 1 cycle for architectural state and 0 cycles visible on the read ports through bypass.
- x0: never written; always reads 0, including when a write to x0 is attempted. Bypass never forwards for index 0.
- Read ports: rsN_data = (wb_we & wb_rd == rsN_addr) ? wb_data : regs[rsN_addr]. Both ports may bypass simultaneously when they hit the same index.
- Inputs other than wb_valid are don't-care when wb_valid=0; no write, no count, no error in that case.
- retire_cnt increments by 1 on every edge with wb_valid=1, whether or not a write occurs (branches and stores count). It wraps to 0 modulo 2^CNT_W with no saturation.
- wb_err: next-cycle value = wb_valid & reg_wen & (wb_sel == 11). It is a single-cycle pulse per offending instruction and is high for consecutive cycles on back-to-back offenders. An illegal instruction still counts as retired.
- No stall/backpressure: the block accepts one instruction per cycle unconditionally.

Test Plan:
- Reset: write regs via traffic, assert rst mid-cycle -> all reads return 0 immediately, retire_cnt=0, wb_err=0, and no write lands on the following edge.
- Source mux: wb_valid=1, reg_wen=1, rd=5; apply sel=00/01/10 on successive cycles with mem_rdata=0xAAAA0001, alu_res=0x12345678, pc_plus4=0x00001004 -> x5 holds each value one cycle later; retire_cnt=3.
- Bypass: rd=7, sel=01, alu_res=0xDEADBEEF, rs1_addr=rs2_addr=7 in the same cycle -> both read 0xDEADBEEF combinationally; with reg_wen=0 the ports return the old x7.
- x0: rd=0, sel=01, alu_res=0xFFFFFFFF -> wb_we=0, rs1_addr=0 reads 0 in that cycle and after; retire_cnt increments.
- Illegal select: sel=11, reg_wen=1, rd=3 for 2 cycles -> x3 unchanged, wb_err high for exactly 2 cycles starting the next edge; sel=11 with reg_wen=0 -> no wb_err.
- Counter/valid: preload retire_cnt to 2^64-1 (force), wb_valid=1 -> wraps to 0; wb_valid=0 with reg_wen=1 -> no write and no count.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: source select, 32-entry integer register file with
// same-cycle write bypass on both read ports, retire counter and illegal-select flag.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_valid,
   input  logic [1:0]       wb_sel,
   input  logic             reg_wen,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  alu_res,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [XLEN-1:0]  pc_plus4,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_we,
   output logic             wb_err,
   output logic [CNT_W-1:0] retire_cnt
);

   logic [XLEN-1:0]  regs [NREG];
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      wb_data = '0;
      unique case (wb_sel)
         2'b00:   wb_data = mem_rdata;
         2'b01:   wb_data = alu_res;
         2'b10:   wb_data = pc_plus4;
         default: wb_data = '0;
      endcase
   end

   // x0 is excluded here, which also keeps the bypass from ever forwarding index 0
   assign wb_we = wb_valid & reg_wen & (wb_rd != '0) & (wb_sel != 2'b11);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Reads are forced to zero while reset is held, bypass included
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (wb_we && (wb_rd == rs1_addr))
         rs1_data = wb_data;
      if (rst)
         rs1_data = '0;
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (wb_we && (wb_rd == rs2_addr))
         rs2_data = wb_data;
      if (rst)
         rs2_data = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wb_err <= 1'b0;
      end else begin
         if (wb_valid)
            cnt_q <= cnt_q + 1'b1;
         wb_err <= wb_valid & reg_wen & (wb_sel == 2'b11);
      end
   end

   assign retire_cnt = cnt_q;

endmodule
